pulse_monitor: RTL
==================

# pulse_monitor

Downstream consumer of the single-bit registered output `y` of the building-block datapath. It samples `y` on every clock and counts rising edges. It measures the high-time of each completed pulse in cycles and offers each measured length to a downstream reader over a valid/ready handshake. It is the first observability stage behind the logic block, used both in silicon debug and as a self-checking monitor in benches.

## Interface
- `CNT_W`, default 8: width of the rising-edge counter; the counter saturates at all-ones.
- `LEN_W`, default 8: width of the pulse-length measurement; the measurement saturates at all-ones.
- `clk` input, 1: single clock; all logic is on its rising edge.
- `rst` input, 1: reset, synchronous and active-high.
- `y_in` input, 1: monitored signal, already synchronous to `clk`.
- `clr` input, 1: synchronous soft clear of statistics and of the result register.
- `edge_cnt` output, CNT_W: number of rising edges since reset or `clr`.
- `len_data` output, LEN_W: length of the held pulse, in cycles.
- `len_valid` output, 1: `len_data` holds an unconsumed result.
- `len_ready` input, 1: downstream accepts the result.
- `overrun` output, 1: sticky flag; a completed pulse was dropped because the result register was full.
- `max_len` output, LEN_W: longest pulse since reset or `clr`; see Configuration.

## Operation
- FSM with two states:
  - `ST_IDLE`: last sample of `y_in` was low.
  - `ST_HIGH`: a pulse is in progress.
- `ST_IDLE` with `y_in`=1:
  - go to `ST_HIGH`;
  - `run_len` <= 1;
  - `edge_cnt` <= `edge_cnt`+1, saturating.
- `ST_HIGH` with `y_in`=1:
  - `run_len` <= `run_len`+1, saturating at 2^LEN_W-1.
- `ST_HIGH` with `y_in`=0:
  - go to `ST_IDLE`;
  - the pulse completes with length `run_len`.
- On pulse completion:
  - If the result register is free, or is freed this cycle by `len_valid && len_ready`, then `len_data` <= `run_len` and `len_valid` <= 1.
  - Otherwise the new length is dropped, `len_data` is kept, and `overrun` <= 1.
- Handshake:
  - The transfer occurs on a cycle with `len_valid && len_ready`.
  - `len_valid` falls on the next edge unless a completion reloads it on that same edge.
  - `len_data` is stable while `len_valid`=1 and not transferred.
  - `len_ready` may be asserted while `len_valid`=0; it has no effect.
- `clr`:
  - clears `edge_cnt`, `overrun`, `max_len`, and `len_valid`/`len_data`;
  - does not touch the FSM or `run_len`, so an in-progress pulse keeps measuring and reports normally after `clr`;
  - a completion in the same cycle as `clr` is discarded;
  - a rising edge in the same cycle as `clr` leaves `edge_cnt`=1.
- A `y_in` that is high when `rst` is released counts as a rising edge.

## Timing
- Reset values: `edge_cnt`=0, `len_data`=0, `len_valid`=0, `overrun`=0, `max_len`=0; FSM in `ST_IDLE`; `run_len`=0.
- `rst` during a pulse abandons that pulse; no result is produced.
- Edge count latency: `y_in` sampled high at edge N in `ST_IDLE` gives the incremented `edge_cnt` visible after edge N.
- Result latency: the first low sample at edge N gives `len_valid`=1 after edge N, i.e. one cycle after `y_in` falls.
- A pulse of k sampled-high cycles reports `len_data`=min(k, 2^LEN_W-1).
- The minimum pulse (1 cycle high) reports 1.
- A pulse can complete and the next one start on consecutive edges; there is no dead cycle.
- The monitor accepts one completion per two cycles maximum, since each pulse needs at least one high and one low sample.

## Configuration
- `PULSE_MONITOR_MAXLEN_EN` defined:
  - `max_len` updates on each completion that is not discarded by `clr`, to max(`max_len`, `run_len`);
  - dropped (overrun) pulses still update `max_len`.
- `PULSE_MONITOR_MAXLEN_EN` undefined:
  - `max_len` is tied to 0;
  - no comparator or register is built;
  - the port list is unchanged.

## Structure
- `pulse_monitor_pkg` holds:
  - `typedef enum logic {ST_IDLE, ST_HIGH} pm_state_e`;
  - default width localparams;
  - function `sat_inc` (saturating increment, width-generic via parameterised class or per-width wrappers).
- One sub-module: `pm_result_reg`, a one-entry valid/ready holding register with load, clear and overrun output. The FSM, counters and max tracking stay in `pulse_monitor`.

## Test plan
- Reset, then a 3-cycle high pulse with `len_ready`=1 -> `edge_cnt`=1; `len_valid` for one cycle with `len_data`=3, one cycle after the fall.
- Two pulses of 2 and 5 cycles with `len_ready`=0 -> first result held (`len_data`=2, `len_valid`=1), `overrun`=1, `edge_cnt`=2; raising `len_ready` drains 2 only.
- Completion in the same cycle as a handshake of the previous result -> no overrun; `len_data` becomes the new length the next cycle.
- `LEN_W`=4, 20-cycle pulse -> `len_data`=15; `CNT_W`=4, 20 pulses -> `edge_cnt`=15.
- `clr` mid-pulse (pulse of 6, `clr` at cycle 3) -> `edge_cnt`=0 and stays 0; `len_data`=6 reported; `clr` coinciding with the fall -> no result.
- With `PULSE_MONITOR_MAXLEN_EN`, pulses 4, 9, 2 -> `max_len`=9; without the macro -> `max_len`=0 throughout.

Source files
------------

// File: rtl/pulse_monitor_pkg.sv
// pulse_monitor_pkg
//   Shared types, default widths and the saturating-increment helper used by
//   pulse_monitor and its result register.
//   Contents:
//     pm_state_e - monitor FSM state (ST_IDLE / ST_HIGH)
//     CNT_W_DEF  - default rising-edge counter width
//     LEN_W_DEF  - default pulse-length width
//     sat_inc()  - width-generic saturating increment (widths up to 32)
package pulse_monitor_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HIGH = 1'b1
  } pm_state_e;

  localparam int unsigned CNT_W_DEF = 32'd8;
  localparam int unsigned LEN_W_DEF = 32'd8;

  // Increment val, holding at the all-ones value of a 'width'-bit field.
  // Callers zero-extend their operand and size-cast the result back.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input int unsigned width);
    logic [31:0] max_v;
    max_v = (32'd1 << width) - 32'd1;
    if (val >= max_v) begin
      sat_inc = max_v;
    end else begin
      sat_inc = val + 32'd1;
    end
  endfunction

endpackage

// File: rtl/pm_result_reg.sv
// pm_result_reg
//   One-entry valid/ready holding register for measured pulse lengths.
//   A load while the entry is free (or being drained this cycle) captures the
//   new value; a load into a full entry is dropped and sets the sticky
//   overrun flag. clr empties the entry, zeroes the data and clears overrun;
//   a load coinciding with clr is discarded.
//   Ports:
//     clk, rst     - clock, synchronous active-high reset
//     clr          - synchronous soft clear
//     load         - a completed measurement is offered
//     load_data    - the offered measurement
//     ready        - downstream accepts the held entry
//     data, valid  - held entry and its valid flag (registered)
//     overrun      - sticky: an offered measurement was dropped (registered)
module pm_result_reg #(
  parameter int unsigned W = 32'd8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic [W-1:0] data,
  output logic         valid,
  output logic         overrun
);

  logic [W-1:0] data_r;
  logic         valid_r;
  logic         overrun_r;
  logic         xfer_s;

  assign xfer_s = valid_r && ready;

  // Holding register: clear dominates, then load, then drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r    <= {W{1'b0}};
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else if (clr) begin
      data_r    <= {W{1'b0}};
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else if (load) begin
      if (!valid_r || xfer_s) begin
        data_r  <= load_data;
        valid_r <= 1'b1;
      end else begin
        overrun_r <= 1'b1;
      end
    end else if (xfer_s) begin
      valid_r <= 1'b0;
    end
  end

  assign data    = data_r;
  assign valid   = valid_r;
  assign overrun = overrun_r;

endmodule

// File: rtl/pulse_monitor.sv
// pulse_monitor
//   Samples y_in every clock, counts rising edges and measures the high time
//   of each completed pulse, offering each length over valid/ready.
//   Optional feature macro: PULSE_MONITOR_MAXLEN_EN builds the longest-pulse
//   tracker; without it max_len is tied to zero (ports unchanged).
//   Ports:
//     clk, rst   - clock, synchronous active-high reset
//     y_in       - monitored signal, synchronous to clk
//     clr        - soft clear of statistics and the result register
//     edge_cnt   - saturating rising-edge count
//     len_data   - held pulse length, len_valid its valid flag
//     len_ready  - downstream accepts len_data
//     overrun    - sticky: a completed pulse was dropped
//     max_len    - longest pulse since reset/clr (zero when feature disabled)
module pulse_monitor
  import pulse_monitor_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             y_in,
  input  logic             clr,
  output logic [CNT_W-1:0] edge_cnt,
  output logic [LEN_W-1:0] len_data,
  output logic             len_valid,
  input  logic             len_ready,
  output logic             overrun,
  output logic [LEN_W-1:0] max_len
);

  pm_state_e        state_r;
  pm_state_e        state_nxt_s;
  logic [LEN_W-1:0] run_len_r;
  logic [LEN_W-1:0] run_len_nxt_s;
  logic [CNT_W-1:0] edge_cnt_r;
  logic             rise_s;
  logic             complete_s;

  // Next-state, run-length update and edge/completion strobes.
  always_comb begin
    state_nxt_s   = state_r;
    run_len_nxt_s = run_len_r;
    rise_s        = 1'b0;
    complete_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (y_in) begin
          state_nxt_s   = ST_HIGH;
          run_len_nxt_s = LEN_W'(1'b1);
          rise_s        = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HIGH: begin
        if (y_in) begin
          run_len_nxt_s = LEN_W'(sat_inc(32'(run_len_r), LEN_W));
        end else begin
          state_nxt_s = ST_IDLE;
          complete_s  = 1'b1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM and run-length registers; clr deliberately leaves these alone so a
  // pulse straddling clr is still measured in full.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      run_len_r <= {LEN_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      run_len_r <= run_len_nxt_s;
    end
  end

  // Saturating rising-edge counter; an edge coinciding with clr counts as 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      edge_cnt_r <= rise_s ? CNT_W'(1'b1) : {CNT_W{1'b0}};
    end else if (rise_s) begin
      edge_cnt_r <= CNT_W'(sat_inc(32'(edge_cnt_r), CNT_W));
    end
  end

  assign edge_cnt = edge_cnt_r;

  // run_len_r still holds the finished pulse's length on the completion cycle.
  pm_result_reg #(
    .W (LEN_W)
  ) u_result (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .load      (complete_s),
    .load_data (run_len_r),
    .ready     (len_ready),
    .data      (len_data),
    .valid     (len_valid),
    .overrun   (overrun)
  );

`ifdef PULSE_MONITOR_MAXLEN_EN
  logic [LEN_W-1:0] max_len_r;

  // Longest-pulse tracker; dropped pulses still count, clr-coincident ones do not.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_len_r <= {LEN_W{1'b0}};
    end else if (clr) begin
      max_len_r <= {LEN_W{1'b0}};
    end else if (complete_s && (run_len_r > max_len_r)) begin
      max_len_r <= run_len_r;
    end
  end

  assign max_len = max_len_r;
`else
  assign max_len = {LEN_W{1'b0}};
`endif

endmodule
